// File: rtl/cout_wb_ctrl.sv
// cout_wb_ctrl: write-back sequencer for RSA output rows into the TB/CB BRAM
// banks (port B). Enables and addresses are registered on the same edge the
// mapping stage registers C_data, so they line up with the mapped dinb.
module cout_wb_ctrl #(
    parameter int X      = 4,
    parameter int L      = 4,
    parameter int RSA_AW = 10,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_mode,
    input  logic [RSA_AW-1:0] cmd_base_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              C_valid,
    output logic [2:0]        C_map_mode,
    output logic [L-1:0]      C_TB_web,
    output logic [RSA_AW-1:0] C_TB_addrb,
    output logic [L-1:0]      C_CB_web,
    output logic [RSA_AW-1:0] C_CB_addrb,
    output logic              busy,
    output logic              wb_done
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t              state_q, state_d;
    logic [2:0]          mode_q, mode_d;
    logic [RSA_AW-1:0]   base_q, base_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [L-1:0]        tb_web_q, tb_web_d;
    logic [L-1:0]        cb_web_q, cb_web_d;
    logic [RSA_AW-1:0]   tb_addr_q, tb_addr_d;
    logic [RSA_AW-1:0]   cb_addr_q, cb_addr_d;
    logic                wb_done_q, wb_done_d;

    logic                tb_sel;
    logic                last_row;
    logic [L-1:0]        row_mask;
    logic [RSA_AW-1:0]   row_addr;

    // Per-bank write mask for a map mode (bit i = bank i).
    function automatic logic [L-1:0] mode_mask(input logic [2:0] m);
        logic [L-1:0] mk;
        mk = '0;
        case (m)
            3'b111, 3'b110: mk = L'(4'b0011);
            3'b100, 3'b101: mk = L'(4'b1100);
            default: begin
                for (int unsigned i = 0; i < unsigned'(L); i++) begin
                    if (i < unsigned'(X)) mk[i] = 1'b1;
                end
            end
        endcase
        return mk;
    endfunction

    assign tb_sel   = (mode_q[2:1] == 2'b00);
    assign row_mask = mode_mask(mode_q);
    assign row_addr = base_q + RSA_AW'(cnt_q);
    assign last_row = (cnt_q == (len_q - LEN_W'(1)));

    // Completion stays "busy" through the wb_done cycle; ready returns after.
    assign cmd_ready  = (state_q == IDLE) && !wb_done_q;
    assign busy       = (state_q != IDLE) || wb_done_q;
    assign wb_done    = wb_done_q;
    assign C_map_mode = mode_q;
    assign C_TB_web   = tb_web_q;
    assign C_CB_web   = cb_web_q;
    assign C_TB_addrb = tb_addr_q;
    assign C_CB_addrb = cb_addr_q;

    // Next-state and registered write-port outputs.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        base_d    = base_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        tb_web_d  = '0;
        cb_web_d  = '0;
        tb_addr_d = tb_addr_q;
        cb_addr_d = cb_addr_q;
        wb_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    mode_d  = cmd_mode;
                    base_d  = cmd_base_addr;
                    len_d   = cmd_len;
                    cnt_d   = '0;
                    state_d = (cmd_len != '0) ? RUN : FLUSH;
                end
            end
            RUN: begin
                if (C_valid) begin
                    if (tb_sel) begin
                        tb_web_d  = row_mask;
                        tb_addr_d = row_addr;
                    end else begin
                        cb_web_d  = row_mask;
                        cb_addr_d = row_addr;
                    end
                    cnt_d = cnt_q + LEN_W'(1);
                    if (last_row) begin
                        wb_done_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            FLUSH: begin
                wb_done_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, asynchronous active-low reset.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            mode_q    <= '0;
            base_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            tb_web_q  <= '0;
            cb_web_q  <= '0;
            tb_addr_q <= '0;
            cb_addr_q <= '0;
            wb_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            base_q    <= base_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            tb_web_q  <= tb_web_d;
            cb_web_q  <= cb_web_d;
            tb_addr_q <= tb_addr_d;
            cb_addr_q <= cb_addr_d;
            wb_done_q <= wb_done_d;
        end
    end

endmodule

// File: tb/tb_cout_wb_ctrl.sv
// Scoreboard bench for cout_wb_ctrl: stimulus pushes expected write events,
// a negedge monitor pops and compares whenever the DUT shows a write or done.
module tb_cout_wb_ctrl;

    localparam int X = 4, L = 4, AW = 10, LW = 8;

    logic          clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_mode = '0;
    logic [AW-1:0] cmd_base_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          C_valid = 1'b0;
    logic [2:0]    C_map_mode;
    logic [L-1:0]  C_TB_web, C_CB_web;
    logic [AW-1:0] C_TB_addrb, C_CB_addrb;
    logic          busy, wb_done;

    cout_wb_ctrl #(.X(X), .L(L), .RSA_AW(AW), .LEN_W(LW)) dut (
        .clk(clk), .sys_rst_n(sys_rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_base_addr(cmd_base_addr), .cmd_len(cmd_len),
        .C_valid(C_valid), .C_map_mode(C_map_mode), .C_TB_web(C_TB_web),
        .C_TB_addrb(C_TB_addrb), .C_CB_web(C_CB_web), .C_CB_addrb(C_CB_addrb),
        .busy(busy), .wb_done(wb_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            at;
        logic [L-1:0]  tbw;
        logic [AW-1:0] tba;
        logic [L-1:0]  cbw;
        logic [AW-1:0] cba;
        logic [2:0]    mode;
        logic          done;
    } ev_t;

    ev_t exp_q[$];
    int  n_total = 0, n_pass = 0;
    int  last_done_cyc = -100;
    bit  prev_done = 0;
    logic [AW-1:0] mdl_tba = '0, mdl_cba = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    endtask

    // Reference mask from the mode table.
    function automatic logic [L-1:0] ref_mask(input logic [2:0] m);
        if (m <= 3'd3) return L'((1 << X) - 1);
        if (m == 3'd7 || m == 3'd6) return 4'b0011;
        return 4'b1100;
    endfunction

    // Monitor: compare every presented write/done against the scoreboard.
    always @(negedge clk) begin
        if (sys_rst_n) begin
            if (prev_done) begin
                chk("ready_after_done", 32'(cmd_ready), 1);
                chk("busy_after_done", 32'(busy), 0);
            end
            prev_done = wb_done;
            if (C_TB_web != '0 || C_CB_web != '0 || wb_done) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_output", {C_TB_web, C_CB_web, 3'b0, wb_done}, 0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("write_cycle", 32'(cyc), 32'(e.at));
                    chk("tb_web", 32'(C_TB_web), 32'(e.tbw));
                    chk("cb_web", 32'(C_CB_web), 32'(e.cbw));
                    chk("tb_addrb", 32'(C_TB_addrb), 32'(e.tba));
                    chk("cb_addrb", 32'(C_CB_addrb), 32'(e.cba));
                    chk("map_mode", 32'(C_map_mode), 32'(e.mode));
                    chk("wb_done", 32'(wb_done), 32'(e.done));
                end
                if (wb_done) begin
                    chk("ready_during_done", 32'(cmd_ready), 0);
                    chk("busy_during_done", 32'(busy), 1);
                    last_done_cyc = cyc;
                end
            end
        end else begin
            prev_done = 0;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Issue one command (held until accepted), then drive its rows.
    // pat (LSB first) gives the strobe pattern when use_pat; abort_after >= 0
    // asserts reset after that many rows.
    task automatic do_cmd(input logic [2:0] mode, input logic [AW-1:0] base,
                          input int len, input int prob, input bit use_pat,
                          input logic [15:0] pat, input int abort_after, input int pre_gap);
        bit held;
        int k, idx, waited, r;
        for (int g = 0; g < pre_gap; g++) begin
            cmd_valid = 1'b0;
            C_valid = 1'($urandom_range(0, 1));
            step();
        end
        C_valid = 1'($urandom_range(0, 1));
        cmd_mode = mode; cmd_base_addr = base; cmd_len = LW'(len);
        cmd_valid = 1'b1;
        held = busy;
        waited = 0;
        while (!cmd_ready && waited < 50) begin
            step();
            C_valid = 1'($urandom_range(0, 1));
            waited++;
        end
        if (!cmd_ready) begin
            chk("cmd_ready_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        r = cyc;
        if (held) chk("held_accept_cycle", 32'(r), 32'(last_done_cyc + 1));
        step();
        cmd_valid = 1'b0;
        C_valid = 1'b0;
        chk("busy_in_cmd", 32'(busy), 1);
        chk("ready_in_cmd", 32'(cmd_ready), 0);
        chk("mode_latched", 32'(C_map_mode), 32'(mode));
        if (len == 0) begin
            ev_t e;
            e = '{at: r + 2, tbw: '0, tba: mdl_tba, cbw: '0, cba: mdl_cba, mode: mode, done: 1'b1};
            exp_q.push_back(e);
            return;
        end
        k = 0; idx = 0;
        while (k < len) begin
            bit s;
            if (abort_after >= 0 && k == abort_after) begin
                C_valid = 1'b0;
                #1 sys_rst_n = 1'b0;
                #1;
                chk("rst_tb_web", 32'(C_TB_web), 0);
                chk("rst_cb_web", 32'(C_CB_web), 0);
                chk("rst_addrs", {C_TB_addrb, C_CB_addrb}, 0);
                chk("rst_busy_done", {busy, wb_done}, 0);
                chk("rst_map_mode", 32'(C_map_mode), 0);
                mdl_tba = '0; mdl_cba = '0;
                step();
                sys_rst_n = 1'b1;
                #1 chk("ready_after_rst", 32'(cmd_ready), 1);
                return;
            end
            s = use_pat ? pat[idx] : ($urandom_range(1, 100) <= prob);
            C_valid = s;
            if (s) begin
                ev_t e;
                e.at = cyc + 1; e.mode = mode; e.done = (k == len - 1);
                if (mode <= 3'd1) begin
                    mdl_tba = base + AW'(k);
                    e.tbw = ref_mask(mode); e.cbw = '0;
                end else begin
                    mdl_cba = base + AW'(k);
                    e.cbw = ref_mask(mode); e.tbw = '0;
                end
                e.tba = mdl_tba; e.cba = mdl_cba;
                exp_q.push_back(e);
                k++;
            end
            idx++;
            step();
        end
        C_valid = 1'b0;
    endtask

    initial begin
        #1;
        chk("reset_webs", {C_TB_web, C_CB_web}, 0);
        chk("reset_addrs", {C_TB_addrb, C_CB_addrb}, 0);
        chk("reset_busy_done", {busy, wb_done}, 0);
        chk("reset_map_mode", 32'(C_map_mode), 0);
        step(); step();
        sys_rst_n = 1'b1;
        #1 chk("ready_after_reset", 32'(cmd_ready), 1);
        step();

        do_cmd(3'b000, 10'h010, 3, 100, 0, '0, -1, 1);            // TB_POS
        do_cmd(3'b011, 10'h3FE, 4, 0, 1, 16'b101101, -1, 2);     // CB_NEG gapped, wraps
        do_cmd(3'b100, 10'h123, 1, 100, 0, '0, -1, 2);            // NEW_00
        do_cmd(3'b110, 10'h124, 1, 100, 0, '0, -1, 0);            // NEW_10 held
        do_cmd(3'b010, 10'h055, 0, 100, 0, '0, -1, 2);            // len=0 flush
        do_cmd(3'b001, 10'h200, 8, 100, 0, '0, 3, 2);             // TB_NEG + reset
        do_cmd(3'b001, 10'h300, 2, 100, 0, '0, -1, 1);            // restart from cnt 0
        for (int i = 0; i < 10; i++) begin
            do_cmd(3'($urandom_range(0, 7)), AW'($urandom_range(0, 1023)),
                   $urandom_range(0, 6), $urandom_range(30, 100), 0, '0, -1,
                   $urandom_range(0, 2));
        end
        for (int i = 0; i < 4; i++) begin
            C_valid = 1'($urandom_range(0, 1));
            step();
        end
        C_valid = 1'b0;
        step();
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $finish;
    end

endmodule

// File: doc/cout_wb_ctrl.md
Name: cout_wb_ctrl

Overview:
- Write-back sequencer for systolic-array (RSA) output rows into the TB and CB BRAM banks through port B.
- Accepts one write-back command per transfer: map mode, base address and row count.
- Drives C_map_mode into the C-output mapping stage, which registers C_data into C_TB_dinb/C_CB_dinb with one cycle of latency.
- Generates per-bank write enables and port-B addresses registered on the same edge, so enables and addresses line up exactly with the mapped data.

Parameters:
X, 4, RSA output lanes per row
L, 4, BRAM banks per buffer (NEW_* modes require L=4, X>=2)
RSA_AW, 10, BRAM port-B address width
LEN_W, 8, row-count width

Ports:
clk  in  1  clock
sys_rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accept; high only in IDLE
cmd_mode  in  3  map mode: 000 TB_POS, 001 TB_NEG, 010 CB_POS, 011 CB_NEG, 111 NEW_11, 100 NEW_00, 101 NEW_01, 110 NEW_10
cmd_base_addr  in  RSA_AW  port-B address of the first row
cmd_len  in  LEN_W  number of rows to write
C_valid  in  1  RSA row strobe; C_data is valid this cycle
C_map_mode  out  3  mode sent to the mapping stage
C_TB_web  out  L  TB per-bank write enable
C_TB_addrb  out  RSA_AW  TB port-B address
C_CB_web  out  L  CB per-bank write enable
C_CB_addrb  out  RSA_AW  CB port-B address
busy  out  1  a command is in progress
wb_done  out  1  one-cycle pulse, aligned with the last write

Behaviour:
- Reset (asynchronous, active-low, takes effect immediately, including mid-transfer):
  - state = IDLE; row counter = 0.
  - C_map_mode = 000; all web = 0; all addrb = 0; busy = 0; wb_done = 0.
  - cmd_ready = 1 once reset is released.
- States are IDLE, RUN and FLUSH.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready, latch mode, base and len; set C_map_mode = mode and cnt = 0 at that edge.
  - Next state is RUN if len != 0, otherwise FLUSH.
  - C_valid is ignored in IDLE.
- RUN:
  - busy = 1; cmd_ready = 0; C_map_mode holds the latched mode.
  - At each edge where C_valid = 1, register enable and address:
    - Selected bank web <= mask; the other bank's web <= 0.
    - Selected bank addrb <= (base + cnt) mod 2^RSA_AW.
    - cnt <= cnt + 1.
  - At each edge where C_valid = 0, both web <= 0 and addrb holds its value.
  - Result: web and addrb are valid in the same cycle that the mapping stage presents the mapped dinb.
- Mask by mode (bit i = bank i):
  - TB_POS and TB_NEG write the TB bank, lanes 0..X-1 set.
  - CB_POS and CB_NEG write the CB bank, lanes 0..X-1 set.
  - NEW_11 and NEW_10 write CB with 4'b0011.
  - NEW_00 and NEW_01 write CB with 4'b1100.
- Last row: at the edge where C_valid = 1 and cnt == len-1:
  - The normal write outputs are registered.
  - wb_done <= 1 in the same cycle the last web is high.
  - Next state is IDLE.
- FLUSH (only for len = 0): wb_done <= 1 for one cycle with no writes, then IDLE.
- After a transfer:
  - busy falls and cmd_ready rises in the cycle after wb_done.
  - C_map_mode keeps the last mode in IDLE; this is harmless because all web = 0.
- Back-to-back commands: a new command is accepted no earlier than the cycle after wb_done, so there is no overlap.
- cmd_valid while busy: stalls, not dropped; the requester holds cmd_valid.
- Addresses wrap modulo 2^RSA_AW; no error is raised.
- Extra C_valid after the last row (in IDLE): ignored, no write.

Test Plan:
- TB_POS, base=0x010, len=3, C_valid on 3 consecutive cycles → C_TB_web = 4'b1111 for 3 cycles starting 1 cycle after the first C_valid; addrb 0x010, 0x011, 0x012; C_CB_web = 0; wb_done high together with the third write.
- CB_NEG, base=0x3FE, len=4, C_valid gapped 1-0-1-1-0-1 → four CB writes at 0x3FE, 0x3FF, 0x000, 0x001, each 1 cycle after its strobe; no writes in the gap cycles.
- NEW_00 then NEW_10, len=1 each, issued back-to-back → C_CB_web = 4'b1100, then 4'b0011; second cmd_ready rises the cycle after the first wb_done; C_map_mode is 100, then 110.
- len=0, CB_POS → accepted; wb_done pulses 2 cycles after acceptance; every web stays 0; cmd_ready returns high the following cycle.
- TB_NEG, len=8, sys_rst_n asserted after 3 writes → web, addrb, busy and wb_done drop to 0 asynchronously; after release, cmd_ready = 1 and a new len=2 command completes normally from cnt = 0.
- C_valid pulsed while IDLE, and cmd_valid held while busy → no writes occur in IDLE; the held command is accepted exactly one cycle after wb_done.
